// File: rtl/sa_sync_pkg.sv
// Shared definitions for the synchronized-level event qualifier.
package sa_sync_pkg;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // Wide enough for the largest stable-cycle count (255).
  localparam int unsigned MIS_W = 8;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_PEND   = 1'b1
  } dbnc_state_e;

  // True when a transition to new_lvl is one of the selected edge kinds.
  function automatic logic edge_qual(input logic [1:0] mode, input logic new_lvl);
    return new_lvl ? |(mode & EDGE_RISE) : |(mode & EDGE_FALL);
  endfunction

endpackage

// File: rtl/sa_sync_dbnc.sv
// Debounce FSM: accepts a new level after STABLE_CYC consecutive mismatching
// samples and emits a one-cycle qualified edge pulse with the level update.
module sa_sync_dbnc
  import sa_sync_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4,
  parameter logic [1:0]  EDGE_MODE  = EDGE_RISE,
  parameter logic        INIT_LVL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_sync,
  output logic lvl,
  output logic edge_p
);

  localparam logic [MIS_W-1:0] MIS_LAST = MIS_W'(STABLE_CYC - 1);

  dbnc_state_e      r_state;
  dbnc_state_e      w_state_nxt;
  logic [MIS_W-1:0] r_mis_cnt;
  logic [MIS_W-1:0] w_mis_nxt;
  logic             r_lvl;
  logic             w_lvl_nxt;
  logic             r_edge_p;
  logic             w_edge_nxt;
  logic             w_accept;
  logic             w_mismatch;

  assign w_mismatch = d_sync ^ r_lvl;

  // State, counter and level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_STABLE;
      r_mis_cnt <= '0;
      r_lvl     <= INIT_LVL;
      r_edge_p  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mis_cnt <= w_mis_nxt;
      r_lvl     <= w_lvl_nxt;
      r_edge_p  <= w_edge_nxt;
    end
  end

  // Next-state logic; an accepted change always lands back in STABLE.
  always_comb begin
    w_state_nxt = r_state;
    w_mis_nxt   = r_mis_cnt;
    w_lvl_nxt   = r_lvl;
    w_edge_nxt  = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_STABLE: begin
        if (w_mismatch) begin
          if (STABLE_CYC == 1) begin
            w_accept = 1'b1;
          end else begin
            w_state_nxt = ST_PEND;
            w_mis_nxt   = MIS_W'(1);
          end
        end
      end
      ST_PEND: begin
        if (!w_mismatch) begin
          w_state_nxt = ST_STABLE;
          w_mis_nxt   = '0;
        end else if (r_mis_cnt == MIS_LAST) begin
          w_accept = 1'b1;
        end else begin
          w_mis_nxt = r_mis_cnt + MIS_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_STABLE;
        w_mis_nxt   = '0;
      end
    endcase
    if (w_accept) begin
      w_state_nxt = ST_STABLE;
      w_mis_nxt   = '0;
      w_lvl_nxt   = d_sync;
      w_edge_nxt  = edge_qual(EDGE_MODE, d_sync);
    end
  end

  assign lvl    = r_lvl;
  assign edge_p = r_edge_p;

endmodule

// File: rtl/sa_sync_evt.sv
// Event qualifier: debounced edges feed a saturating pending-event counter
// drained one per cycle by a valid/ready consumer, with sticky overflow.
module sa_sync_evt
  import sa_sync_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned CNT_W      = 8,
  parameter logic [1:0]  EDGE_MODE  = EDGE_RISE,
  parameter logic        INIT_LVL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_sync,
  input  logic             en,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             lvl,
  output logic             edge_p,
  output logic             ovf,
  input  logic             clr_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             w_edge_p;
  logic             w_event;
  logic             w_pop;
  logic             w_ovf_set;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_pend_cnt;
  logic             r_evt_valid;
  logic             r_ovf;

  sa_sync_dbnc #(
    .STABLE_CYC (STABLE_CYC),
    .EDGE_MODE  (EDGE_MODE),
    .INIT_LVL   (INIT_LVL)
  ) u_dbnc (
    .clk    (clk),
    .rst    (rst),
    .d_sync (d_sync),
    .lvl    (lvl),
    .edge_p (w_edge_p)
  );

  assign w_event   = w_edge_p & en;
  assign w_pop     = r_evt_valid & evt_ready;
  assign w_ovf_set = w_event & ~w_pop & (r_pend_cnt == CNT_MAX);

  // Simultaneous event and pop cancel; increments saturate at CNT_MAX.
  always_comb begin
    w_cnt_nxt = r_pend_cnt;
    if (w_event && !w_pop) begin
      if (r_pend_cnt != CNT_MAX) begin
        w_cnt_nxt = r_pend_cnt + CNT_W'(1);
      end
    end else if (w_pop && !w_event) begin
      w_cnt_nxt = r_pend_cnt - CNT_W'(1);
    end
  end

  // evt_valid is registered alongside the count so it has no input-to-output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_cnt  <= '0;
      r_evt_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_pend_cnt  <= w_cnt_nxt;
      r_evt_valid <= (w_cnt_nxt != '0);
      r_ovf       <= w_ovf_set | (r_ovf & ~clr_ovf);
    end
  end

  assign edge_p    = w_edge_p;
  assign pend_cnt  = r_pend_cnt;
  assign evt_valid = r_evt_valid;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_sa_sync_evt.sv
// Bench for sa_sync_evt: three configurations share one stimulus stream, a
// per-cycle reference model feeds a scoreboard, and a segment table adds fixed checks.
module tb_sa_sync_evt;
  import sa_sync_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, d_sync, en, evt_ready, clr_ovf;
  logic [2:0] lvl_w, edge_w, vld_w, ovf_w;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [2:0] cnt_c;

  sa_sync_evt #(.STABLE_CYC(4), .CNT_W(8), .EDGE_MODE(EDGE_BOTH), .INIT_LVL(1'b0)) u_a (
    .clk(clk), .rst(rst), .d_sync(d_sync), .en(en), .evt_valid(vld_w[0]),
    .evt_ready(evt_ready), .pend_cnt(cnt_a), .lvl(lvl_w[0]), .edge_p(edge_w[0]),
    .ovf(ovf_w[0]), .clr_ovf(clr_ovf));

  sa_sync_evt #(.STABLE_CYC(4), .CNT_W(2), .EDGE_MODE(EDGE_RISE), .INIT_LVL(1'b0)) u_b (
    .clk(clk), .rst(rst), .d_sync(d_sync), .en(en), .evt_valid(vld_w[1]),
    .evt_ready(evt_ready), .pend_cnt(cnt_b), .lvl(lvl_w[1]), .edge_p(edge_w[1]),
    .ovf(ovf_w[1]), .clr_ovf(clr_ovf));

  sa_sync_evt #(.STABLE_CYC(1), .CNT_W(3), .EDGE_MODE(EDGE_FALL), .INIT_LVL(1'b0)) u_c (
    .clk(clk), .rst(rst), .d_sync(d_sync), .en(en), .evt_valid(vld_w[2]),
    .evt_ready(evt_ready), .pend_cnt(cnt_c), .lvl(lvl_w[2]), .edge_p(edge_w[2]),
    .ovf(ovf_w[2]), .clr_ovf(clr_ovf));

  localparam int         P_S   [3] = '{4, 4, 1};
  localparam int         P_MAX [3] = '{255, 3, 7};
  localparam logic [1:0] P_EM  [3] = '{EDGE_BOTH, EDGE_RISE, EDGE_FALL};

  typedef struct packed {
    logic [2:0]      lvl;
    logic [2:0]      edg;
    logic [2:0]      vld;
    logic [2:0]      ovf;
    logic [2:0][7:0] cnt;
  } exp_t;

  typedef struct {
    logic d, en, rdy, clr, rs;
    int   n;
    logic e_lvl;
    int   e_cnt_a;
    int   e_cnt_b;
    logic e_ovf_b;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];

  int   m_run[3], m_cnt[3];
  logic m_lvl[3], m_edge[3], m_ovf[3];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, got, exp);
    end
  endtask

  // Reference: a run of STABLE_CYC mismatching samples flips the level.
  task automatic model_step(input logic d, input logic e, input logic r, input logic c,
                            input logic rs);
    logic ev, pop, set;
    for (int i = 0; i < 3; i++) begin
      if (rs) begin
        m_lvl[i] = 1'b0; m_run[i] = 0; m_edge[i] = 1'b0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
      end else begin
        ev  = m_edge[i] & e;
        pop = (m_cnt[i] != 0) & r;
        set = ev && !pop && (m_cnt[i] == P_MAX[i]);
        if (ev && !pop && m_cnt[i] < P_MAX[i]) m_cnt[i]++;
        else if (pop && !ev) m_cnt[i]--;
        m_ovf[i]  = set ? 1'b1 : (c ? 1'b0 : m_ovf[i]);
        m_edge[i] = 1'b0;
        if (d != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == P_S[i]) begin
            m_edge[i] = d ? P_EM[i][0] : P_EM[i][1];
            m_lvl[i]  = d;
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  endtask

  task automatic tick(input logic d, input logic e, input logic r, input logic c, input logic rs);
    exp_t x;
    logic [2:0][7:0] got_cnt;
    d_sync = d; en = e; evt_ready = r; clr_ovf = c; rst = rs;
    model_step(d, e, r, c, rs);
    for (int i = 0; i < 3; i++) begin
      x.lvl[i] = m_lvl[i];
      x.edg[i] = m_edge[i];
      x.vld[i] = (m_cnt[i] != 0);
      x.ovf[i] = m_ovf[i];
      x.cnt[i] = 8'(m_cnt[i]);
    end
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    cyc++;
    x = sb_q.pop_front();
    got_cnt[0] = cnt_a;
    got_cnt[1] = {6'b0, cnt_b};
    got_cnt[2] = {5'b0, cnt_c};
    for (int i = 0; i < 3; i++) begin
      check($sformatf("dut%0d.lvl", i),       32'(lvl_w[i]),   32'(x.lvl[i]));
      check($sformatf("dut%0d.edge_p", i),    32'(edge_w[i]),  32'(x.edg[i]));
      check($sformatf("dut%0d.evt_valid", i), 32'(vld_w[i]),   32'(x.vld[i]));
      check($sformatf("dut%0d.ovf", i),       32'(ovf_w[i]),   32'(x.ovf[i]));
      check($sformatf("dut%0d.pend_cnt", i),  32'(got_cnt[i]), 32'(x.cnt[i]));
    end
  endtask

  task automatic add(input logic d, input logic e, input logic r, input logic c, input logic rs,
                     input int n, input logic el, input int ea, input int eb, input logic eo);
    vec_t v;
    v.d = d; v.en = e; v.rdy = r; v.clr = c; v.rs = rs; v.n = n;
    v.e_lvl = el; v.e_cnt_a = ea; v.e_cnt_b = eb; v.e_ovf_b = eo;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; d_sync = 1'b0; en = 1'b1; evt_ready = 1'b0; clr_ovf = 1'b0;
    //  d  en rdy clr rst  n   lvlA cntA cntB ovfB
    add(0, 1, 0, 0, 1, 2,  0,  0,  0, 0);   // reset
    add(1, 1, 0, 0, 0, 3,  0,  0,  0, 0);   // 3-cycle glitch
    add(0, 1, 0, 0, 0, 3,  0,  0,  0, 0);
    add(1, 1, 0, 0, 0, 6,  1,  1,  1, 0);   // three full pulses, no pops
    add(0, 1, 0, 0, 0, 6,  0,  2,  1, 0);
    add(1, 1, 0, 0, 0, 6,  1,  3,  2, 0);
    add(0, 1, 0, 0, 0, 6,  0,  4,  2, 0);
    add(1, 1, 0, 0, 0, 6,  1,  5,  3, 0);
    add(0, 1, 0, 0, 0, 6,  0,  6,  3, 0);
    add(0, 1, 1, 0, 0, 7,  0,  0,  0, 0);   // drain
    add(1, 1, 0, 0, 0, 5,  1,  1,  1, 0);   // rising events toward saturation
    add(0, 1, 0, 0, 0, 5,  0,  2,  1, 0);
    add(1, 1, 0, 0, 0, 5,  1,  3,  2, 0);
    add(0, 1, 0, 0, 0, 5,  0,  4,  2, 0);
    add(1, 1, 0, 0, 0, 5,  1,  5,  3, 0);
    add(0, 1, 0, 0, 0, 5,  0,  6,  3, 0);
    add(1, 1, 0, 0, 0, 5,  1,  7,  3, 1);
    add(0, 1, 0, 0, 0, 5,  0,  8,  3, 1);
    add(1, 1, 0, 0, 0, 5,  1,  9,  3, 1);
    add(0, 1, 0, 0, 0, 5,  0, 10,  3, 1);
    add(1, 1, 0, 0, 0, 4,  1, 10,  3, 1);   // edge pending
    add(1, 1, 0, 1, 0, 1,  1, 11,  3, 1);   // clear coincides with overflow
    add(1, 1, 0, 1, 0, 1,  1, 11,  3, 0);   // plain clear
    add(0, 1, 0, 0, 0, 4,  0, 11,  3, 0);
    add(0, 1, 1, 0, 0, 1,  0, 11,  2, 0);   // event and pop together on A
    add(1, 0, 0, 0, 0, 5,  1, 11,  2, 0);   // edge with en low
    add(0, 1, 0, 0, 0, 2,  1, 11,  2, 0);   // mid-debounce
    add(1, 1, 0, 0, 1, 1,  0,  0,  0, 0);   // reset discards everything
    add(1, 1, 0, 0, 0, 3,  0,  0,  0, 0);
    add(1, 1, 0, 0, 0, 1,  1,  0,  0, 0);   // edge STABLE_CYC cycles after release
    add(1, 1, 0, 0, 0, 1,  1,  1,  1, 0);

    foreach (tbl[k]) begin
      for (int j = 0; j < tbl[k].n; j++)
        tick(tbl[k].d, tbl[k].en, tbl[k].rdy, tbl[k].clr, tbl[k].rs);
      check($sformatf("seg%0d.lvl_a", k),  32'(lvl_w[0]), 32'(tbl[k].e_lvl));
      check($sformatf("seg%0d.cnt_a", k),  32'(cnt_a),    32'(tbl[k].e_cnt_a));
      check($sformatf("seg%0d.cnt_b", k),  32'(cnt_b),    32'(tbl[k].e_cnt_b));
      check($sformatf("seg%0d.ovf_b", k),  32'(ovf_w[1]), 32'(tbl[k].e_ovf_b));
    end

    // Hand-written: edge_p is present on the 4th sample after reset release and gone next.
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("hand.edge_before", 32'(edge_w[0]), 32'd0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("hand.edge_at", 32'(edge_w[0]), 32'd1);
    check("hand.valid_at", 32'(vld_w[0]), 32'd0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("hand.edge_after", 32'(edge_w[0]), 32'd0);
    check("hand.valid_after", 32'(vld_w[0]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
